// File: rtl/ternary_alu.sv
// Balanced-ternary ALU: 2 bits per trit (11=-1, 00=0, 01=+1), one-cycle registered result.
// Define TERNARY_ALU_SHIFT_EN to build the SRI/SLI trit shifter; otherwise those opcodes yield zero.
module ternary_alu #(
    parameter int WORD_SIZE = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alu_enable,
    input  logic [5:0]             opcode,
    input  logic [2*WORD_SIZE-1:0] input1,
    input  logic [2*WORD_SIZE-1:0] input2,
    output logic [2*WORD_SIZE-1:0] alu_out
);
    localparam int W = 2 * WORD_SIZE;

    localparam logic [5:0] OP_MV   = 6'b000000;
    localparam logic [5:0] OP_NOT  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001100;
    localparam logic [5:0] OP_ADD  = 6'b001101;
    localparam logic [5:0] OP_SUB  = 6'b001111;
    localparam logic [5:0] OP_EQ   = 6'b010011;
    localparam logic [5:0] OP_ANDI = 6'b010100;
    localparam logic [5:0] OP_ADDI = 6'b010101;
    localparam logic [5:0] OP_SRI  = 6'b010111;
    localparam logic [5:0] OP_SLI  = 6'b011100;
    localparam logic [5:0] OP_LT   = 6'b011111;

    localparam logic [W-1:0] WORD_ONE = {{(W-2){1'b0}}, 2'b01};

    typedef logic signed [2:0] tval_t;

    function automatic tval_t trit_val(input logic [1:0] t);
        case (t)
            2'b01:   return 3'sd1;
            2'b11:   return -3'sd1;
            default: return 3'sd0;
        endcase
    endfunction

    function automatic logic [1:0] trit_enc(input tval_t v);
        if (v > 3'sd0)      return 2'b01;
        else if (v < 3'sd0) return 2'b11;
        else                return 2'b00;
    endfunction

    // The unused code 2'b10 is folded to zero here so no later stage can emit it.
    function automatic logic [W-1:0] norm_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < WORD_SIZE; i++) r[2*i +: 2] = trit_enc(trit_val(w[2*i +: 2]));
        return r;
    endfunction

    function automatic logic [W-1:0] neg_word(input logic [W-1:0] a);
        logic [W-1:0] r;
        for (int i = 0; i < WORD_SIZE; i++) r[2*i +: 2] = trit_enc(-trit_val(a[2*i +: 2]));
        return r;
    endfunction

    // mode 0: min, 1: max, 2: carry-free sum
    function automatic logic [W-1:0] trit_logic(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [1:0] mode);
        logic [W-1:0] r;
        tval_t ta, tb, s;
        for (int i = 0; i < WORD_SIZE; i++) begin
            ta = trit_val(a[2*i +: 2]);
            tb = trit_val(b[2*i +: 2]);
            case (mode)
                2'd0:    s = (ta < tb) ? ta : tb;
                2'd1:    s = (ta > tb) ? ta : tb;
                default: begin
                    s = ta + tb;
                    if (s > 3'sd1)       s = s - 3'sd3;
                    else if (s < -3'sd1) s = s + 3'sd3;
                end
            endcase
            r[2*i +: 2] = trit_enc(s);
        end
        return r;
    endfunction

    // Ripple add; the carry out of the top trit is dropped, giving wrap modulo 3^WORD_SIZE.
    function automatic logic [W-1:0] add_words(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        tval_t c, s;
        c = 3'sd0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            s = trit_val(a[2*i +: 2]) + trit_val(b[2*i +: 2]) + c;
            if (s > 3'sd1) begin
                s = s - 3'sd3;
                c = 3'sd1;
            end else if (s < -3'sd1) begin
                s = s + 3'sd3;
                c = -3'sd1;
            end else begin
                c = 3'sd0;
            end
            r[2*i +: 2] = trit_enc(s);
        end
        return r;
    endfunction

    // The most significant differing trit decides the signed order.
    function automatic logic less_than(input logic [W-1:0] a, input logic [W-1:0] b);
        logic lt;
        tval_t ta, tb;
        lt = 1'b0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            ta = trit_val(a[2*i +: 2]);
            tb = trit_val(b[2*i +: 2]);
            if (ta != tb) lt = (ta < tb);
        end
        return lt;
    endfunction

`ifdef TERNARY_ALU_SHIFT_EN
    function automatic logic [W-1:0] shift_word(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic left);
        int n;
        n = 0;
        for (int i = WORD_SIZE - 1; i >= 0; i--) n = n * 3 + int'(trit_val(b[2*i +: 2]));
        if (n <= 0)         return a;
        if (n >= WORD_SIZE) return '0;
        return left ? (a << (2 * n)) : (a >> (2 * n));
    endfunction
`endif

    logic [W-1:0] a_n, b_n, result;
    logic [W-1:0] alu_out_d, alu_out_q;
    logic [5:0]   op_n;

    always_comb begin
        a_n  = norm_word(input1);
        b_n  = norm_word(input2);
        op_n = {trit_enc(trit_val(opcode[5:4])), trit_enc(trit_val(opcode[3:2])),
                trit_enc(trit_val(opcode[1:0]))};
    end

    always_comb begin
        result = '0;
        case (op_n)
            OP_MV:           result = a_n;
            OP_NOT:          result = neg_word(a_n);
            OP_AND, OP_ANDI: result = trit_logic(a_n, b_n, 2'd0);
            OP_OR:           result = trit_logic(a_n, b_n, 2'd1);
            OP_XOR:          result = trit_logic(a_n, b_n, 2'd2);
            OP_ADD, OP_ADDI: result = add_words(a_n, b_n);
            OP_SUB:          result = add_words(a_n, neg_word(b_n));
            OP_EQ:           result = (a_n == b_n) ? WORD_ONE : '0;
            OP_LT:           result = less_than(a_n, b_n) ? WORD_ONE : '0;
`ifdef TERNARY_ALU_SHIFT_EN
            OP_SRI:          result = shift_word(a_n, b_n, 1'b0);
            OP_SLI:          result = shift_word(a_n, b_n, 1'b1);
`endif
            default:         result = '0;
        endcase
    end

    always_comb begin
        alu_out_d = alu_out_q;
        if (alu_enable) alu_out_d = result;
    end

    always_ff @(posedge clock) begin
        if (reset) alu_out_q <= '0;
        else       alu_out_q <= alu_out_d;
    end

    assign alu_out = alu_out_q;

endmodule

// File: tb/tb_ternary_alu.sv
// Bench for ternary_alu: directed checks plus randomized ops against an integer-arithmetic model.
// Honours TERNARY_ALU_SHIFT_EN the same way the design does.
module tb_ternary_alu;
    localparam int WS = 9;
    localparam int W  = 2 * WS;

    localparam logic [5:0] OP_MV   = 6'b000000;
    localparam logic [5:0] OP_NOT  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001100;
    localparam logic [5:0] OP_ADD  = 6'b001101;
    localparam logic [5:0] OP_SUB  = 6'b001111;
    localparam logic [5:0] OP_EQ   = 6'b010011;
    localparam logic [5:0] OP_ANDI = 6'b010100;
    localparam logic [5:0] OP_ADDI = 6'b010101;
    localparam logic [5:0] OP_SRI  = 6'b010111;
    localparam logic [5:0] OP_SLI  = 6'b011100;
    localparam logic [5:0] OP_LT   = 6'b011111;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         alu_enable = 1'b0;
    logic [5:0]   opcode = '0;
    logic [W-1:0] input1 = '0;
    logic [W-1:0] input2 = '0;
    logic [W-1:0] alu_out;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_state = '0;
    logic [5:0]   op_table[16];

    always #5 clock = ~clock;

    ternary_alu #(.WORD_SIZE(WS)) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_enable (alu_enable),
        .opcode     (opcode),
        .input1     (input1),
        .input2     (input2),
        .alu_out    (alu_out)
    );

    function automatic int trit_of(input logic [W-1:0] w, input int i);
        case (w[2*i +: 2])
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int to_int(input logic [W-1:0] w);
        int v, p;
        v = 0;
        p = 1;
        for (int i = 0; i < WS; i++) begin
            v = v + trit_of(w, i) * p;
            p = p * 3;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] from_int(input int v);
        logic [W-1:0] r;
        int m, d;
        m = ((v + 9841) % 19683 + 19683) % 19683 - 9841;
        r = '0;
        for (int i = 0; i < WS; i++) begin
            d = ((m % 3) + 3) % 3;
            if (d == 2) begin
                r[2*i +: 2] = 2'b11;
                m = (m + 1) / 3;
            end else if (d == 1) begin
                r[2*i +: 2] = 2'b01;
                m = (m - 1) / 3;
            end else begin
                m = m / 3;
            end
        end
        return r;
    endfunction

    // kind 0: min, 1: max, 2: (x+y) mod 3 balanced, 3: shift right by n, 4: shift left by n
    function automatic logic [W-1:0] per_trit(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input int kind, input int n);
        int acc, p, x, y, t, src;
        acc = 0;
        p = 1;
        for (int i = 0; i < WS; i++) begin
            x = trit_of(a, i);
            y = trit_of(b, i);
            case (kind)
                0:       t = (x < y) ? x : y;
                1:       t = (x > y) ? x : y;
                2:       t = ((x + y + 4) % 3) - 1;
                3: begin src = i + n; t = (src < WS) ? trit_of(a, src) : 0; end
                default: begin src = i - n; t = (src >= 0) ? trit_of(a, src) : 0; end
            endcase
            acc = acc + t * p;
            p = p * 3;
        end
        return from_int(acc);
    endfunction

    function automatic logic [W-1:0] model(input logic [5:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int va, vb, n;
        va = to_int(a);
        vb = to_int(b);
        n  = vb;
        case (op)
            OP_MV:           return from_int(va);
            OP_NOT:          return from_int(-va);
            OP_AND, OP_ANDI: return per_trit(a, b, 0, 0);
            OP_OR:           return per_trit(a, b, 1, 0);
            OP_XOR:          return per_trit(a, b, 2, 0);
            OP_ADD, OP_ADDI: return from_int(va + vb);
            OP_SUB:          return from_int(va - vb);
            OP_EQ:           return from_int((va == vb) ? 1 : 0);
            OP_LT:           return from_int((va < vb) ? 1 : 0);
`ifdef TERNARY_ALU_SHIFT_EN
            OP_SRI, OP_SLI: begin
                if (n <= 0)  return from_int(va);
                if (n >= WS) return '0;
                return per_trit(a, b, (op == OP_SRI) ? 3 : 4, n);
            end
`endif
            default:         return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%05h (%0d) expected=%05h (%0d) at %0t",
                     tag, got, to_int(got), want, to_int(want), $time);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic en, input logic [5:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] want);
        @(negedge clock);
        reset      = rst;
        alu_enable = en;
        opcode     = op;
        input1     = a;
        input2     = b;
        if (rst)     exp_state = '0;
        else if (en) exp_state = want;
        exp_q.push_back(exp_state);
        @(posedge clock);
        #1;
        check(tag, alu_out, exp_q.pop_front());
    endtask

    initial begin
        logic [5:0]   op;
        logic [W-1:0] a, b;
        logic         rst, en;
        logic [W-1:0] all_minus;
        logic [W-1:0] all_bad;
        all_minus = '1;
        all_bad   = 18'h2AAAA;

        op_table = '{OP_MV, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_EQ,
                     OP_ANDI, OP_ADDI, OP_SRI, OP_SLI, OP_LT, 6'b111111, 6'b110100, 6'b000001};

        step("reset", 1'b1, 1'b0, OP_MV, '0, '0, '0);
        step("reset_hold", 1'b1, 1'b1, OP_MV, from_int(77), '0, '0);

        step("not",  1'b0, 1'b1, OP_NOT, from_int(-24), '0, from_int(24));
        step("and",  1'b0, 1'b1, OP_AND, from_int(19), from_int(-17), from_int(-35));
        step("or",   1'b0, 1'b1, OP_OR,  from_int(19), from_int(-17), from_int(37));
        step("xor",  1'b0, 1'b1, OP_XOR, from_int(19), from_int(-17), from_int(-1));
        step("add",  1'b0, 1'b1, OP_ADD, from_int(118), from_int(-1), from_int(117));
        step("sub",  1'b0, 1'b1, OP_SUB, from_int(118), from_int(-107), from_int(225));
        step("addi", 1'b0, 1'b1, OP_ADDI, from_int(118), from_int(-107), from_int(11));
        step("addi_m1", 1'b0, 1'b1, OP_ADDI, all_minus, from_int(1), {all_minus[W-1:2], 2'b00});
        step("wrap_add", 1'b0, 1'b1, OP_ADD, from_int(9841), from_int(1), from_int(-9841));
        step("wrap_sub", 1'b0, 1'b1, OP_SUB, from_int(-9841), from_int(1), from_int(9841));
        step("eq_same", 1'b0, 1'b1, OP_EQ, from_int(4), from_int(4), from_int(1));
        step("eq_diff", 1'b0, 1'b1, OP_EQ, from_int(4), from_int(3), '0);
        step("lt_true", 1'b0, 1'b1, OP_LT, from_int(-6), from_int(12), from_int(1));
        step("lt_false", 1'b0, 1'b1, OP_LT, from_int(12), from_int(-6), '0);
        step("lt_equal", 1'b0, 1'b1, OP_LT, from_int(7), from_int(7), '0);
`ifdef TERNARY_ALU_SHIFT_EN
        step("sri3", 1'b0, 1'b1, OP_SRI, from_int(1093), from_int(3), from_int(40));
        step("sli9", 1'b0, 1'b1, OP_SLI, from_int(1093), from_int(9), '0);
        step("sri_neg", 1'b0, 1'b1, OP_SRI, from_int(1093), from_int(-2), from_int(1093));
        step("sli1", 1'b0, 1'b1, OP_SLI, from_int(40), from_int(1), from_int(120));
`else
        step("sri_off", 1'b0, 1'b1, OP_SRI, from_int(1093), from_int(3), '0);
        step("sli_off", 1'b0, 1'b1, OP_SLI, from_int(1093), from_int(1), '0);
`endif
        step("mv_norm", 1'b0, 1'b1, OP_MV, all_bad, '0, '0);
        step("run", 1'b0, 1'b1, OP_ADD, from_int(100), from_int(23), from_int(123));
        step("hold", 1'b0, 1'b0, OP_SUB, from_int(5), from_int(7), '0);
        step("hold2", 1'b0, 1'b0, OP_NOT, from_int(-300), '0, '0);
        step("rst_en", 1'b1, 1'b1, OP_ADD, from_int(1), from_int(1), from_int(2));
        step("post_rst", 1'b0, 1'b1, OP_MV, from_int(42), '0, from_int(42));
        step("undef", 1'b0, 1'b1, 6'b111111, from_int(42), from_int(5), '0);

        for (int k = 0; k < 400; k++) begin
            op = op_table[$urandom_range(0, 15)];
            a  = W'($urandom_range(0, (1 << W) - 1));
            b  = W'($urandom_range(0, (1 << W) - 1));
            if ((op == OP_SRI || op == OP_SLI) && $urandom_range(0, 3) != 0)
                b = from_int(int'($urandom_range(0, 12)) - 2);
            if ((op == OP_EQ || op == OP_LT) && $urandom_range(0, 3) == 0)
                b = a;
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 31) == 0);
            step("rand", rst, en, op, a, b, model(op, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ternary_alu.md
TERNARY_ALU -- requirements
Module: ternary_alu

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: WORD_SIZE, default 9, trits per word; each port below is 2*WORD_SIZE bits wide, and only 9 is required.
REQ-003 Port: clock, input, 1, rising-edge clock.
REQ-004 Port: reset, input, 1, synchronous active-high reset.
REQ-005 Port: alu_enable, input, 1, a result is registered on a clock edge only when this is high.
REQ-006 Port: opcode, input, 6, three trits (2 bits each).
REQ-007 Port: input1, input, 18, operand A (9 trits).
REQ-008 Port: input2, input, 18, operand B, immediate, or shift amount.
REQ-009 Port: alu_out, output, 18, registered result.

Function
REQ-010 Trit encoding SHALL be 2'b11 = -1, 2'b00 = 0, 2'b01 = +1; an input of 2'b10 SHALL be treated as 0, and 2'b10 SHALL never be output.
REQ-011 Trit i SHALL occupy bits [2i+1:2i]; trit 0 is least significant; words are balanced-ternary signed, range ±9841.
REQ-012 Opcodes SHALL be: MV 000000, NOT 000011, AND 000101, OR 000111, XOR 001100, ADD 001101, SUB 001111, EQ 010011, ANDI 010100, ADDI 010101, SRI 010111, SLI 011100, LT 011111.
REQ-013 MV: result = input1.
REQ-014 NOT: per-trit negation of input1.
REQ-015 AND/ANDI: per-trit min(A,B); OR: per-trit max(A,B).
REQ-016 XOR: per-trit carry-free sum, (A+B) mod 3 mapped to {-1,0,1}.
REQ-017 ADD/ADDI: A+B with ripple carry; result wraps modulo 3^9, and the final carry is discarded.
REQ-018 SUB: A+NOT(B), with the same wrap rule.
REQ-019 EQ: result is +1 in trit 0 (other trits 0) if A==B, else all-zero.
REQ-020 LT: result is +1 in trit 0 if signed A<B, else all-zero.
REQ-021 SRI/SLI: logical trit shift of input1 right/left by n = signed value of input2; vacated trits are filled with 0.
REQ-022 Shift amount: n<=0 SHALL pass input1 unchanged; n>=9 SHALL give all-zero.
REQ-023 An undefined opcode SHALL give an all-zero result.
REQ-024 Latency SHALL be one cycle: the result of the inputs present at edge k appears on alu_out after edge k.
REQ-025 Holding: when alu_enable=0, alu_out SHALL hold its value and input changes SHALL have no effect.
REQ-026 The combinational path SHALL depend only on opcode, input1 and input2; there is no other internal state.

Reset
REQ-027 When reset is high at a rising clock edge, alu_out SHALL become all-zero (18'b0).
REQ-028 Reset SHALL take priority over alu_enable.
REQ-029 An operation in flight when reset is asserted SHALL be discarded.
REQ-030 After reset deasserts, the first enabled edge SHALL produce a normal result.

Configuration
REQ-031 Macro TERNARY_ALU_SHIFT_EN defined: SRI and SLI are implemented per REQ-021/022.
REQ-032 Macro TERNARY_ALU_SHIFT_EN undefined: the shifter is omitted and SRI/SLI behave as undefined opcodes (all-zero); all other opcodes are unchanged.

Verification
REQ-033 Logic check: NOT on [..,-1,0,1,0] -> [..,1,0,-1,0]; AND of A=[..,1,-1,0,1], B=[..,-1,1,0,1] -> [..,-1,-1,0,1]; OR of the same -> [..,1,1,0,1]; XOR of the same -> [..,0,0,0,-1].
REQ-034 Arithmetic check: ADD 118 + (-1) -> 117; SUB 118 - (-107) -> 225; ADDI 118 + (-107) -> 11; ADDI all -1 + 1 -> all -1 with trit 0 = 0.
REQ-035 Wrap check: ADD 9841 + 1 -> -9841; SUB (-9841) - 1 -> 9841.
REQ-036 Compare check: EQ on equal operands -> 1; EQ differing in trit 0 -> 0; LT 0xA<B (A=-6, B=12) -> 1; LT A=12, B=-6 -> 0; LT on equal operands -> 0.
REQ-037 Shift check (with TERNARY_ALU_SHIFT_EN): SRI of 1093 (seven +1 trits) by 3 -> 40; SLI by 9 -> 0; shift by -2 -> input1 unchanged.
REQ-038 Control check: after reset, alu_out = 0; with alu_enable=0 and inputs changed, alu_out holds; reset asserted together with alu_enable=1 -> 0; an undefined opcode -> 0.
